instruction_decode: RTL and testbench

- Second pipeline stage of the 16-bit core. Sits directly downstream of the fetch stage.
- Consumes the fetch stage's NPC_IF/INST_IF pipeline register, decodes the instruction, and reads operands from an internal 16x16 register file (write port driven by writeback).
- Registers the ID/EX pipeline bundle.
- Detects load-use hazards: stalls fetch and inserts a bubble.
- Honours flushes from taken branches.

---
 rtl/core_pkg.sv | 44 ++++
 rtl/regfile_16x16.sv | 47 ++++
 rtl/instruction_decode.sv | 139 +++++++++++++
 tb/tb_instruction_decode.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core: opcodes, field positions and
// the ID/EX pipeline bundle.
package core_pkg;

    localparam int XLEN   = 16;
    localparam int REG_AW = 4;
    localparam int NREGS  = 16;

    localparam logic [XLEN-1:0] NOP = 16'h0000;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RD_HI = 11;
    localparam int RD_LO = 8;
    localparam int RS_HI = 7;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 0;

    typedef struct packed {
        logic [XLEN-1:0]   npc;
        logic [XLEN-1:0]   opa;
        logic [XLEN-1:0]   opb;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic [3:0]        op;
        logic              regwr;
        logic              memrd;
        logic              memwr;
        logic              br;
    } id_ex_t;

endpackage

// File: rtl/regfile_16x16.sv
// 16x16 register file: two combinational read ports with write-through,
// one synchronous write port, r0 hardwired to zero.
module regfile_16x16
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [XLEN-1:0]   rdata_a,
    output logic [XLEN-1:0]   rdata_b,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = mem[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && waddr == raddr_a) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = mem[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && waddr == raddr_b) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decodes the IF/ID instruction, reads operands, detects
// load-use hazards and registers the ID/EX bundle.
module instruction_decode
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   NPC_IF,
    input  logic [XLEN-1:0]   INST_IF,
    input  logic              FLUSH,
    input  logic              WB_EN,
    input  logic [REG_AW-1:0] WB_ADDR,
    input  logic [XLEN-1:0]   WB_DATA,
    output logic              STALL,
    output logic [XLEN-1:0]   NPC_ID,
    output logic [XLEN-1:0]   OPA_ID,
    output logic [XLEN-1:0]   OPB_ID,
    output logic [XLEN-1:0]   IMM_ID,
    output logic [REG_AW-1:0] RD_ID,
    output logic [3:0]        OP_ID,
    output logic              REGWR_ID,
    output logic              MEMRD_ID,
    output logic              MEMWR_ID,
    output logic              BR_ID
);

    id_ex_t q, d;

    logic [3:0]        op;
    logic [REG_AW-1:0] rd, rs, rt;
    logic [REG_AW-1:0] raddr_a, raddr_b;
    logic [XLEN-1:0]   rdata_a, rdata_b;
    logic [XLEN-1:0]   imm;
    logic              is_alu, is_addi, is_load;
    logic              is_store, is_beq, is_jmp;
    logic              use_rd, use_rs, use_rt;
    logic              valid, hit;

    assign op = INST_IF[OP_HI:OP_LO];
    assign rd = INST_IF[RD_HI:RD_LO];
    assign rs = INST_IF[RS_HI:RS_LO];
    assign rt = INST_IF[RT_HI:RT_LO];

    assign is_alu   = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    assign is_addi  = (op == OP_ADDI);
    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);
    assign is_beq   = (op == OP_BEQ);
    assign is_jmp   = (op == OP_JMP);

    assign valid = is_alu | is_addi | is_load
                 | is_store | is_beq | is_jmp;

    always_comb begin
        use_rd = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        imm    = '0;
        unique case (1'b1)
            is_alu, is_store: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            is_addi: begin
                use_rd = 1'b1;
                imm    = {{8{INST_IF[7]}}, INST_IF[7:0]};
            end
            is_load: use_rs = 1'b1;
            is_beq: begin
                use_rd = 1'b1;
                use_rs = 1'b1;
                imm    = {{12{INST_IF[3]}}, INST_IF[3:0]};
            end
            is_jmp: imm = {{4{INST_IF[11]}}, INST_IF[11:0]};
            default: ;
        endcase
    end

    // Port A carries rd for ADDI, port B carries rd for ADDI and BEQ.
    assign raddr_a = is_addi ? rd : rs;
    assign raddr_b = use_rd ? rd : rt;

    regfile_16x16 u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .we      (WB_EN),
        .waddr   (WB_ADDR),
        .wdata   (WB_DATA)
    );

    assign hit = (q.rd != '0)
               && ((use_rd && rd == q.rd)
                || (use_rs && rs == q.rd)
                || (use_rt && rt == q.rd));

    assign STALL = !FLUSH && q.memrd && hit;

    always_comb begin
        d = '0;
        if (valid) begin
            d.npc   = NPC_IF;
            d.opa   = (use_rs | use_rd) ? rdata_a : '0;
            d.opb   = (use_rt | use_rd) ? rdata_b : '0;
            d.imm   = imm;
            d.regwr = is_alu | is_addi | is_load;
            d.rd    = d.regwr ? rd : '0;
            d.op    = op;
            d.memrd = is_load;
            d.memwr = is_store;
            d.br    = is_beq | is_jmp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (FLUSH || STALL) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    assign NPC_ID   = q.npc;
    assign OPA_ID   = q.opa;
    assign OPB_ID   = q.opb;
    assign IMM_ID   = q.imm;
    assign RD_ID    = q.rd;
    assign OP_ID    = q.op;
    assign REGWR_ID = q.regwr;
    assign MEMRD_ID = q.memrd;
    assign MEMWR_ID = q.memwr;
    assign BR_ID    = q.br;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed table, hazard sequences and
// random stimulus against a behavioural model.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] NPC_IF, INST_IF;
    logic        FLUSH, WB_EN;
    logic [3:0]  WB_ADDR;
    logic [15:0] WB_DATA;
    logic        STALL;
    logic [15:0] NPC_ID, OPA_ID, OPB_ID, IMM_ID;
    logic [3:0]  RD_ID, OP_ID;
    logic        REGWR_ID, MEMRD_ID, MEMWR_ID, BR_ID;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .NPC_IF   (NPC_IF),
        .INST_IF  (INST_IF),
        .FLUSH    (FLUSH),
        .WB_EN    (WB_EN),
        .WB_ADDR  (WB_ADDR),
        .WB_DATA  (WB_DATA),
        .STALL    (STALL),
        .NPC_ID   (NPC_ID),
        .OPA_ID   (OPA_ID),
        .OPB_ID   (OPB_ID),
        .IMM_ID   (IMM_ID),
        .RD_ID    (RD_ID),
        .OP_ID    (OP_ID),
        .REGWR_ID (REGWR_ID),
        .MEMRD_ID (MEMRD_ID),
        .MEMWR_ID (MEMWR_ID),
        .BR_ID    (BR_ID)
    );

    typedef struct packed {
        logic [15:0] npc, opa, opb, imm;
        logic [3:0]  rd, op;
        logic        regwr, memrd, memwr, br;
    } mo_t;

    typedef struct {
        logic [15:0] inst, npc;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [15:0] opa, opb, imm;
        logic [3:0]  rd, op, ctl;
    } vec_t;

    mo_t         m_q;
    logic [15:0] m_regs [16];
    int          n_chk  = 0;
    int          n_pass = 0;
    bit          mchk   = 1'b0;
    logic        last_stall;
    vec_t        tv [12];

    function automatic mo_t act();
        return {NPC_ID, OPA_ID, OPB_ID, IMM_ID, RD_ID, OP_ID,
                REGWR_ID, MEMRD_ID, MEMWR_ID, BR_ID};
    endfunction

    function automatic mo_t mk(logic [15:0] npc, opa, opb, imm,
                               logic [3:0] rd, op, ctl);
        return {npc, opa, opb, imm, rd, op, ctl};
    endfunction

    task automatic chk(string nm, logic [79:0] a, logic [79:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, a, e);
    endtask

    // Reference: register value seen by ID this cycle.
    function automatic logic [15:0] mread(logic [3:0] a);
        if (a == 4'd0) return 16'h0;
        if (WB_EN && WB_ADDR == a) return WB_DATA;
        return m_regs[a];
    endfunction

    function automatic bit m_uses(logic [15:0] i, logic [3:0] r);
        case (i[15:12])
            4'h1, 4'h2, 4'h3, 4'h4, 4'h9: return r == i[7:4] || r == i[3:0];
            4'h5: return r == i[11:8];
            4'hC: return r == i[11:8] || r == i[7:4];
            4'h8: return r == i[7:4];
            default: return 1'b0;
        endcase
    endfunction

    function automatic mo_t m_decode(logic [15:0] i, logic [15:0] npc);
        mo_t o = '0;
        case (i[15:12])
            4'h1, 4'h2, 4'h3, 4'h4: begin
                o.opa = mread(i[7:4]); o.opb = mread(i[3:0]);
                o.rd = i[11:8]; o.regwr = 1'b1;
            end
            4'h5: begin
                o.opa = mread(i[11:8]); o.opb = o.opa;
                o.imm = 16'($signed(i[7:0]));
                o.rd = i[11:8]; o.regwr = 1'b1;
            end
            4'h8: begin
                o.opa = mread(i[7:4]); o.rd = i[11:8];
                o.regwr = 1'b1; o.memrd = 1'b1;
            end
            4'h9: begin
                o.opa = mread(i[7:4]); o.opb = mread(i[3:0]);
                o.memwr = 1'b1;
            end
            4'hC: begin
                o.opa = mread(i[7:4]); o.opb = mread(i[11:8]);
                o.imm = 16'($signed(i[3:0])); o.br = 1'b1;
            end
            4'hD: begin
                o.imm = 16'($signed(i[11:0])); o.br = 1'b1;
            end
            default: return '0;
        endcase
        o.npc = npc;
        o.op  = i[15:12];
        return o;
    endfunction

    task automatic cycle(input logic rst, input logic [15:0] inst,
                         input logic [15:0] npc, input logic fl,
                         input logic we, input logic [3:0] wa,
                         input logic [15:0] wd);
        logic ms;
        mo_t  nx;
        @(negedge clk);
        rst_n = rst; INST_IF = inst; NPC_IF = npc; FLUSH = fl;
        WB_EN = we; WB_ADDR = wa; WB_DATA = wd;
        #1;
        ms = !fl && m_q.memrd && m_q.rd != 0 && m_uses(inst, m_q.rd);
        if (!rst) nx = '0;
        else if (fl || ms) nx = '0;
        else nx = m_decode(inst, npc);
        last_stall = STALL;
        if (mchk) chk("model_stall", 80'(STALL), 80'(ms));
        @(posedge clk);
        m_q = nx;
        if (!rst) begin
            for (int r = 0; r < 16; r++) m_regs[r] = 16'h0;
        end else if (we && wa != 0) begin
            m_regs[wa] = wd;
        end
        #1;
        if (mchk) chk("model_bundle", 80'(act()), 80'(m_q));
    endtask

    initial begin
        logic [15:0] ri;
        m_q = '0;
        rst_n = 1'b1; INST_IF = 16'h0; NPC_IF = 16'h0; FLUSH = 1'b0;
        WB_EN = 1'b0; WB_ADDR = 4'h0; WB_DATA = 16'h0;

        // Write r1 before reset so the post-reset read is meaningful.
        cycle(1, 16'h0000, 16'h0, 0, 1, 4'd1, 16'h1234);
        cycle(0, 16'h1123, 16'h10, 0, 0, 4'd0, 16'h0);
        mchk = 1'b1;
        cycle(0, 16'h1123, 16'h10, 0, 0, 4'd0, 16'h0);
        chk("reset_bundle", 80'(act()), 80'(0));
        chk("reset_stall", 80'(last_stall), 80'(0));
        cycle(1, 16'h1110, 16'h20, 0, 0, 4'd0, 16'h0);
        chk("reset_r1_zero", 80'(OPA_ID), 80'(0));

        cycle(1, 16'h0000, 16'h0, 0, 1, 4'd1, 16'h1111);
        cycle(1, 16'h0000, 16'h0, 0, 1, 4'd2, 16'h2222);
        cycle(1, 16'h0000, 16'h0, 0, 1, 4'd4, 16'h0123);
        cycle(1, 16'h0000, 16'h0, 0, 1, 4'd7, 16'h7777);

        tv[0]  = '{16'h1320, 16'h0100, 1, 4'd2, 16'h00AA,
                   16'h00AA, 16'h0000, 16'h0000, 4'd3, 4'h1, 4'b1000};
        tv[1]  = '{16'h54F0, 16'h0101, 0, 4'd0, 16'h0000,
                   16'h0123, 16'h0123, 16'hFFF0, 4'd4, 4'h5, 4'b1000};
        tv[2]  = '{16'hD800, 16'h0102, 0, 4'd0, 16'h0000,
                   16'h0000, 16'h0000, 16'hF800, 4'd0, 4'hD, 4'b0001};
        tv[3]  = '{16'hF123, 16'h0103, 0, 4'd0, 16'h0000,
                   16'h0000, 16'h0000, 16'h0000, 4'd0, 4'h0, 4'b0000};
        tv[4]  = '{16'h1100, 16'h0104, 1, 4'd0, 16'hFFFF,
                   16'h0000, 16'h0000, 16'h0000, 4'd1, 4'h1, 4'b1000};
        tv[5]  = '{16'h9127, 16'h0105, 0, 4'd0, 16'h0000,
                   16'h00AA, 16'h7777, 16'h0000, 4'd0, 4'h9, 4'b0010};
        tv[6]  = '{16'hC417, 16'h0106, 0, 4'd0, 16'h0000,
                   16'h1111, 16'h0123, 16'h0007, 4'd0, 4'hC, 4'b0001};
        tv[7]  = '{16'hC41F, 16'h0107, 0, 4'd0, 16'h0000,
                   16'h1111, 16'h0123, 16'hFFFF, 4'd0, 4'hC, 4'b0001};
        tv[8]  = '{16'h2712, 16'h0108, 0, 4'd0, 16'h0000,
                   16'h1111, 16'h00AA, 16'h0000, 4'd7, 4'h2, 4'b1000};
        tv[9]  = '{16'h8710, 16'h0109, 0, 4'd0, 16'h0000,
                   16'h1111, 16'h0000, 16'h0000, 4'd7, 4'h8, 4'b1100};
        tv[10] = '{16'h3123, 16'h010A, 0, 4'd0, 16'h0000,
                   16'h00AA, 16'h0000, 16'h0000, 4'd1, 4'h3, 4'b1000};
        tv[11] = '{16'h7000, 16'h010B, 0, 4'd0, 16'h0000,
                   16'h0000, 16'h0000, 16'h0000, 4'd0, 4'h0, 4'b0000};

        for (int i = 0; i < 12; i++) begin
            cycle(1, tv[i].inst, tv[i].npc, 0, tv[i].we, tv[i].wa, tv[i].wd);
            chk($sformatf("vec%0d_bundle", i), 80'(act()),
                80'(mk((tv[i].op != 0) ? tv[i].npc : 16'h0,
                       tv[i].opa, tv[i].opb, tv[i].imm,
                       tv[i].rd, tv[i].op, tv[i].ctl)));
            chk($sformatf("vec%0d_stall", i), 80'(last_stall), 80'(0));
        end

        // Load-use with a writeback landing during the stall.
        cycle(1, 16'h8510, 16'h0200, 0, 0, 4'd0, 16'h0);
        cycle(1, 16'h1652, 16'h0201, 0, 1, 4'd9, 16'h9999);
        chk("lu_stall", 80'(last_stall), 80'(1));
        chk("lu_bubble", 80'(act()), 80'(0));
        cycle(1, 16'h1652, 16'h0201, 0, 0, 4'd0, 16'h0);
        chk("lu_release", 80'(last_stall), 80'(0));
        chk("lu_issue", 80'(act()),
            80'(mk(16'h0201, 16'h0000, 16'h00AA, 16'h0, 4'd6, 4'h1, 4'b1000)));
        cycle(1, 16'h1190, 16'h0202, 0, 0, 4'd0, 16'h0);
        chk("wb_in_stall", 80'(OPA_ID), 80'(16'h9999));

        // Flush overrides the hazard.
        cycle(1, 16'h8510, 16'h0300, 0, 0, 4'd0, 16'h0);
        cycle(1, 16'h1652, 16'h0301, 1, 0, 4'd0, 16'h0);
        chk("fl_nostall", 80'(last_stall), 80'(0));
        chk("fl_bubble", 80'(act()), 80'(0));
        cycle(1, 16'h1652, 16'h0302, 0, 0, 4'd0, 16'h0);
        chk("fl_no_second", 80'(last_stall), 80'(0));
        chk("fl_rd", 80'(RD_ID), 80'(6));

        // Reset arriving mid-stall.
        cycle(1, 16'h8510, 16'h0400, 0, 0, 4'd0, 16'h0);
        cycle(0, 16'h1652, 16'h0401, 0, 0, 4'd0, 16'h0);
        chk("rs_stall", 80'(last_stall), 80'(1));
        chk("rs_bubble", 80'(act()), 80'(0));
        cycle(1, 16'h1652, 16'h0401, 0, 0, 4'd0, 16'h0);
        chk("rs_release", 80'(last_stall), 80'(0));
        chk("rs_rd", 80'(RD_ID), 80'(6));

        for (int n = 0; n < 400; n++) begin
            ri = 16'($urandom);
            ri[11] = 1'b0;
            ri[7]  = ri[7] & ri[15];
            ri[3]  = 1'b0;
            if ($urandom_range(0, 3) == 0) ri[15:12] = 4'h8;
            cycle(($urandom_range(0, 49) != 0), ri, 16'($urandom),
                  ($urandom_range(0, 9) == 0), 1'($urandom),
                  4'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
